// File: rtl/cache_req_master.sv
// Request sequencer between the load/store unit and cache_Memory_top: buffers CPU requests,
// issues one strobe per request, waits out the cache stall, and returns a one-cycle response.
// Optional stall watchdog: define CACHE_REQ_TIMEOUT_EN.
module cache_req_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [9:0]  Word_address,
  output logic [31:0] Data_In,
  input  logic        stall,
  input  logic [31:0] Data_Out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic        fifo_w [DEPTH];
  logic [9:0]  fifo_a [DEPTH];
  logic [31:0] fifo_d [DEPTH];
  logic        full, empty, push, done, to_hit;
  logic        kind_q, kind_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_write_q, rsp_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

`ifdef CACHE_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
      $error("cache_req_master: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end
  endgenerate

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty     = (wptr_q == rptr_q);
  assign req_ready = rst && !full;
  assign push      = req_valid && req_ready;
  assign busy      = !empty || (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_w[wptr_q[AW-1:0]] <= req_write;
      fifo_a[wptr_q[AW-1:0]] <= req_addr;
      fifo_d[wptr_q[AW-1:0]] <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    to_hit  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (!empty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!stall) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
`ifdef CACHE_REQ_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          done    = 1'b1;
          to_hit  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Mem_Read  = (state_q == S_ISSUE) && !kind_q;
    Mem_Write = (state_q == S_ISSUE) && kind_q;
  end

  // The head entry stays in the FIFO until completion; it is only copied out here.
  always_comb begin
    kind_d = kind_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == S_IDLE && !empty) begin
      kind_d = fifo_w[rptr_q[AW-1:0]];
      addr_d = fifo_a[rptr_q[AW-1:0]];
      data_d = fifo_d[rptr_q[AW-1:0]];
    end
    wptr_d      = push ? wptr_q + (AW + 1)'(1) : wptr_q;
    rptr_d      = done ? rptr_q + (AW + 1)'(1) : rptr_q;
    rsp_valid_d = done;
    rsp_write_d = done && kind_q;
    rsp_rdata_d = (done && !kind_q && !to_hit) ? Data_Out : '0;
`ifdef CACHE_REQ_TIMEOUT_EN
    cnt_d = cnt_q;
    if (state_q == S_ISSUE)             cnt_d = '0;
    else if (state_q == S_WAIT && stall) cnt_d = cnt_q + CW'(1);
    rsp_err_d = to_hit;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      kind_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef CACHE_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign Word_address = addr_q;
  assign Data_In      = data_q;

endmodule

// File: tb/tb_cache_req_master.sv
// Scoreboard bench for cache_req_master with a behavioural cache model driving stall/Data_Out.
module tb_cache_req_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_write, rsp_err, busy, Mem_Read, Mem_Write;
  logic [31:0] rsp_rdata, Data_In;
  logic [9:0]  Word_address;
  logic        stall = 1'b0;
  logic [31:0] Data_Out = '0;

  always #5 clk = ~clk;

  cache_req_master #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Word_address(Word_address), .Data_In(Data_In),
    .stall(stall), .Data_Out(Data_Out)
  );

  typedef struct packed {logic w; logic [9:0] a; logic [31:0] d;} strb_t;
  typedef struct packed {logic w; logic [31:0] rd; logic err;} rsp_t;

  strb_t sq[$];
  rsp_t  rq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  hold = 1'b0;
  int    stall_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Cache model: stall for stall_n WAIT cycles (or while hold), write on Mem_Write.
  initial begin : cache_model
    logic [31:0] cmem [1024];
    logic        waiting;
    int          k, n;
    for (int i = 0; i < 1024; i++) cmem[i] = '0;
    cmem[10'h38B] = 32'd2;
    cmem[10'h0C6] = 32'hC6C6_0001;
    cmem[10'h0EB] = 32'hEBEB_0002;
    cmem[10'h3A9] = 32'hA9A9_0003;
    cmem[10'h1F0] = 32'hF0F0_0004;
    waiting = 1'b0;
    k = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        waiting = 1'b0;
        stall   = 1'b0;
      end else if (Mem_Read || Mem_Write) begin
        if (Mem_Write) cmem[Word_address] = Data_In;
        Data_Out = cmem[Word_address];
        waiting  = 1'b1;
        k = 0;
        n = stall_n;
        stall = 1'b0;
      end else if (waiting) begin
        k++;
        stall = hold || (k <= n);
        if (!stall) waiting = 1'b0;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes the cache or responds.
  initial begin : monitor
    logic        prev_rsp, in_txn;
    logic [9:0]  ta;
    logic [31:0] td;
    strb_t       s;
    rsp_t        r;
    prev_rsp = 1'b0;
    in_txn   = 1'b0;
    ta = '0;
    td = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_rsp = 1'b0;
        in_txn   = 1'b0;
      end else begin
        if (Mem_Read || Mem_Write) begin
          chk("single_strobe", {63'd0, Mem_Read & Mem_Write}, 64'd0);
          if (sq.size() == 0) fail("unexpected_strobe");
          else begin
            s = sq.pop_front();
            chk("strobe_kind", {63'd0, Mem_Write}, {63'd0, s.w});
            chk("strobe_addr", {54'd0, Word_address}, {54'd0, s.a});
            if (s.w) chk("strobe_wdata", {32'd0, Data_In}, {32'd0, s.d});
          end
          in_txn = 1'b1;
          ta = Word_address;
          td = Data_In;
        end else if (in_txn) begin
          chk("addr_data_hold", {22'd0, Word_address, Data_In}, {22'd0, ta, td});
        end
        if (rsp_valid) begin
          chk("rsp_not_back_to_back", {63'd0, prev_rsp}, 64'd0);
          if (rq.size() == 0) fail("unexpected_rsp");
          else begin
            r = rq.pop_front();
            chk("rsp_write", {63'd0, rsp_write}, {63'd0, r.w});
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, r.rd});
            chk("rsp_err",   {63'd0, rsp_err},   {63'd0, r.err});
          end
          in_txn = 1'b0;
        end
        prev_rsp = rsp_valid;
      end
    end
  end

  task automatic push(input logic w, input logic [9:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        @(posedge clk);
        sq.push_back('{w: w, a: a, d: d});
        rq.push_back('{w: w, rd: exp_rd, err: exp_err});
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
    if (!ok) fail("push_timeout");
  endtask

  // Cycle index (counted in negedges after the accepting edge) of first strobe and of response.
  task automatic measure(output int si, output int ri);
    si = 0;
    ri = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if ((Mem_Read || Mem_Write) && si == 0) si = i;
      if (rsp_valid) begin
        ri = i;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && rq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("idle_timeout");
  endtask

  initial begin : stimulus
    int si, ri;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
    chk("reset_busy",      {63'd0, busy},      64'd0);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_strobes",   {62'd0, Mem_Read, Mem_Write}, 64'd0);
    chk("reset_addr_data", {22'd0, Word_address, Data_In}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

    // Single load, 3 stall cycles
    stall_n = 3;
    push(1'b0, 10'b111_00010_11, 32'd0, 32'd2, 1'b0);
    measure(si, ri);
    chk("load_strobe_cycle", 64'(si), 64'd2);
    chk("load_rsp_cycle",    64'(ri), 64'd7);
    wait_idle();

    // Store, then read it back on a hit
    stall_n = 2;
    push(1'b1, 10'b111_00010_01, 32'd100, 32'd0, 1'b0);
    wait_idle();
    stall_n = 0;
    push(1'b0, 10'b111_00010_01, 32'd0, 32'd100, 1'b0);
    measure(si, ri);
    chk("hit_rsp_cycle", 64'(ri), 64'd4);
    wait_idle();

`ifndef CACHE_REQ_TIMEOUT_EN
    // Fill FIFO while the cache stalls; fifth request must wait for a pop
    hold = 1'b1;
    push(1'b0, 10'h0C6, 32'd0, 32'hC6C6_0001, 1'b0);
    push(1'b0, 10'h0EB, 32'd0, 32'hEBEB_0002, 1'b0);
    push(1'b0, 10'h3A9, 32'd0, 32'hA9A9_0003, 1'b0);
    push(1'b1, 10'h005, 32'd7, 32'd0, 1'b0);
    @(negedge clk);
    chk("full_ready_low", {63'd0, req_ready}, 64'd0);
    chk("full_busy",      {63'd0, busy},      64'd1);
    fork
      push(1'b0, 10'h1F0, 32'd0, 32'hF0F0_0004, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("held_ready_low", {63'd0, req_ready}, 64'd0);
        end
        hold = 1'b0;
      end
    join
    wait_idle();
    push(1'b0, 10'h005, 32'd0, 32'd7, 1'b0);
    wait_idle();
`else
    // Stall stuck high: watchdog completes with an error after 8 WAIT cycles
    hold = 1'b1;
    push(1'b0, 10'h0C6, 32'd0, 32'd0, 1'b1);
    measure(si, ri);
    chk("timeout_strobe_cycle", 64'(si), 64'd2);
    chk("timeout_rsp_cycle",    64'(ri), 64'd11);
    hold = 1'b0;
    wait_idle();
    push(1'b0, 10'h0EB, 32'd0, 32'hEBEB_0002, 1'b0);
    wait_idle();
`endif

    // Reset while a transaction waits and another is queued
    hold = 1'b1;
    push(1'b0, 10'h0C6, 32'd0, 32'hC6C6_0001, 1'b0);
    push(1'b0, 10'h0EB, 32'd0, 32'hEBEB_0002, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_strobes",   {62'd0, Mem_Read, Mem_Write}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    sq.delete();
    rq.delete();
    hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy",  {63'd0, busy},      64'd0);
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
    stall_n = 1;
    push(1'b0, 10'h3A9, 32'd0, 32'hA9A9_0003, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("strobe_queue_drained", 64'(sq.size()), 64'd0);
    chk("rsp_queue_drained",    64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
